// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: selects reset/redirect/held/incremented PC,
// drives the instruction-memory request and flushes IF/ID after an accepted redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        misalign_reg, misalign_next;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect = jmp_i | br_taken_i;
    assign target   = jmp_i ? jmp_target_i : br_target_i;
    assign pc_inc   = pc_reg + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= {RESET_VECTOR[31:2], 2'b00};
            cnt_reg      <= 3'd0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        cnt_next      = cnt_reg;
        misalign_next = 1'b0;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN, FLUSH: begin
                // A redirect wins over stall, ack and the flush countdown alike.
                if (redirect) begin
                    if (target[1:0] == 2'b00) begin
                        pc_next    = target;
                        state_next = FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end else begin
                        misalign_next = 1'b1;
                        state_next    = HALT;
                    end
                end else if (state_reg == RUN) begin
                    if (imem_ack_i && !stall_i) begin
                        pc_next = pc_inc;
                    end
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    assign imem_req_o  = (state_reg == RUN);
    assign imem_addr_o = pc_reg;
    assign pc_o        = pc_reg;
    assign pc_plus4_o  = pc_inc;
    assign flush_o     = (state_reg == FLUSH);
    assign misalign_o  = misalign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, sequential fetch, stalls, redirects, flush
// reload, PC wrap, misaligned-target halt and reset out of FLUSH/HALT.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        jmp_i;
    logic [31:0] jmp_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        flush_o;
    logic        misalign_o;

    int checks_total;
    int checks_passed;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .jmp_i       (jmp_i),
        .jmp_target_i(jmp_target_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .flush_o     (flush_o),
        .misalign_o  (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; prints one line per cycle.
    task automatic step(input string what);
        @(posedge clk);
        #1;
        $display("[%0t] %-14s pc=%h req=%b addr=%h flush=%b mis=%b",
                 $time, what, pc_o, imem_req_o, imem_addr_o, flush_o, misalign_o);
    endtask

    // Checks the four main observables in one call.
    task automatic expect_state(input string tag, input logic [31:0] pc, input logic req,
                                input logic fl, input logic mis);
        check_eq({tag, ".pc"},    pc_o,        pc);
        check_eq({tag, ".req"},   {31'd0, imem_req_o}, {31'd0, req});
        check_eq({tag, ".flush"}, {31'd0, flush_o},    {31'd0, fl});
        check_eq({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, mis});
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;  stall_i = 1'b0;  imem_ack_i = 1'b0;
        br_taken_i = 1'b0;  br_target_i = 32'd0;
        jmp_i = 1'b0;  jmp_target_i = 32'd0;

        // Boot: one bubble after reset, then request at the reset vector.
        step("reset");
        expect_state("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("run0");
        expect_state("boot_done", 32'h0, 1'b1, 1'b0, 1'b0);
        check_eq("boot_addr", imem_addr_o, 32'h0);

        // Sequential fetch with stall holding the PC.
        imem_ack_i = 1'b1;
        step("ack");      check_eq("seq1", pc_o, 32'h4);
        step("ack");      check_eq("seq2", pc_o, 32'h8);
        stall_i = 1'b1;
        step("ack+stall"); expect_state("stall1", 32'h8, 1'b1, 1'b0, 1'b0);
        step("ack+stall"); check_eq("stall2", pc_o, 32'h8);
        check_eq("stall_addr", imem_addr_o, 32'h8);
        stall_i = 1'b0;
        step("release");  check_eq("release", pc_o, 32'hC);
        check_eq("plus4", pc_plus4_o, 32'h10);
        imem_ack_i = 1'b0;
        step("no_ack");   expect_state("no_ack", 32'hC, 1'b1, 1'b0, 1'b0);

        // Branch overrides stall; flush for two cycles, ack ignored meanwhile.
        br_taken_i = 1'b1; br_target_i = 32'h100; stall_i = 1'b1; imem_ack_i = 1'b1;
        step("branch");   expect_state("br", 32'h100, 1'b0, 1'b1, 1'b0);
        br_taken_i = 1'b0; stall_i = 1'b0;
        step("flush2");   expect_state("br_fl2", 32'h100, 1'b0, 1'b1, 1'b0);
        imem_ack_i = 1'b0;
        step("resume");   expect_state("br_run", 32'h100, 1'b1, 1'b0, 1'b0);
        check_eq("br_addr", imem_addr_o, 32'h100);

        // Jump beats branch; redirect in first flush cycle reloads the counter.
        jmp_i = 1'b1; jmp_target_i = 32'h200; br_taken_i = 1'b1; br_target_i = 32'h300;
        step("jmp+br");   expect_state("prio", 32'h200, 1'b0, 1'b1, 1'b0);
        jmp_i = 1'b0; br_target_i = 32'h400;
        step("reload");   expect_state("reload", 32'h400, 1'b0, 1'b1, 1'b0);
        br_taken_i = 1'b0;
        step("flush2");   expect_state("reload_fl2", 32'h400, 1'b0, 1'b1, 1'b0);
        step("resume");   expect_state("reload_run", 32'h400, 1'b1, 1'b0, 1'b0);

        // PC wrap at the top of the address space.
        jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
        step("jmp_top");  check_eq("top", pc_o, 32'hFFFF_FFFC);
        jmp_i = 1'b0;
        step("flush2");
        step("resume");   check_eq("top_req", {31'd0, imem_req_o}, 32'd1);
        check_eq("top_plus4", pc_plus4_o, 32'h0);
        imem_ack_i = 1'b1;
        step("wrap");     check_eq("wrap", pc_o, 32'h0);
        imem_ack_i = 1'b0;

        // Reset in the middle of FLUSH.
        jmp_i = 1'b1; jmp_target_i = 32'h500;
        step("jmp");      expect_state("pre_rst", 32'h500, 1'b0, 1'b1, 1'b0);
        jmp_i = 1'b0; rst = 1'b1;
        step("rst_flush"); expect_state("rst_fl", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("run");      check_eq("rst_fl_run", {31'd0, imem_req_o}, 32'd1);

        // Misaligned target: one-cycle pulse, PC unchanged, halted until reset.
        jmp_i = 1'b1; jmp_target_i = 32'h102;
        step("jmp_mis");  expect_state("mis", 32'h0, 1'b0, 1'b0, 1'b1);
        jmp_i = 1'b0;
        step("halt");     expect_state("halt1", 32'h0, 1'b0, 1'b0, 1'b0);
        br_taken_i = 1'b1; br_target_i = 32'h800; imem_ack_i = 1'b1;
        step("halt_br");  expect_state("halt2", 32'h0, 1'b0, 1'b0, 1'b0);
        br_taken_i = 1'b0; imem_ack_i = 1'b0; rst = 1'b1;
        step("rst_halt"); expect_state("rst_halt", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("boot");     check_eq("halt_boot", {31'd0, imem_req_o}, 32'd1);

        // Misaligned branch target in FLUSH also halts.
        jmp_i = 1'b1; jmp_target_i = 32'h40;
        step("jmp");      check_eq("fl_mis_pre", pc_o, 32'h40);
        jmp_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h41;
        step("br_mis");   expect_state("fl_mis", 32'h40, 1'b0, 1'b0, 1'b1);
        br_taken_i = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
